// File: rtl/motor_step_gen.sv
// Step/direction pulse generator with a linear speed ramp and a direction-setup hold.
// Optional signed step-position counter is compiled in with `define STEP_POS_EN.
module motor_step_gen #(
    parameter int unsigned HALF_START = 2500,
    parameter int unsigned HALF_MIN   = 250,
    parameter int unsigned RAMP_STEP  = 10,
    parameter int unsigned DIR_SETUP  = 50,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [1:0]       motor_flag,
`ifdef STEP_POS_EN
    input  logic             pos_clr,
    output logic [CNT_W-1:0] step_pos,
`endif
    output logic             motor_step,
    output logic             motor_dir,
    output logic             motor_en,
    output logic             busy
);

    if (HALF_MIN < 1 || HALF_START < HALF_MIN || HALF_START > 65535 || DIR_SETUP < 1 ||
        DIR_SETUP > 65535 || CNT_W < 1) begin : g_param_check
        $error("motor_step_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StHigh, StLow} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] half_q, half_d;
    logic [15:0] half_ramp;
    logic        dir_q, dir_d;
    logic        step_q, en_q;
    logic        run_req, flag_dir, cnt_last;

    // Clamp against HALF_MIN before subtracting so the half-period never underflows.
    assign half_ramp = (32'(half_q) >= HALF_MIN + RAMP_STEP) ? half_q - 16'(RAMP_STEP)
                                                             : 16'(HALF_MIN);
    assign run_req   = (motor_flag == 2'd1) || (motor_flag == 2'd2);
    assign flag_dir  = (motor_flag == 2'd2);
    assign cnt_last  = (cnt_q <= 16'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        dir_d   = dir_q;
        case (state_q)
            StIdle: begin
                if (run_req) begin
                    dir_d   = flag_dir;
                    half_d  = 16'(HALF_START);
                    cnt_d   = 16'(DIR_SETUP);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (!run_req) begin
                    state_d = StIdle;
                end else if (cnt_last) begin
                    cnt_d   = half_q;
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StHigh: begin
                if (cnt_last) begin
                    cnt_d   = half_q;
                    state_d = StLow;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StLow: begin
                // Stop and reversal are only honoured here so a pulse is never cut short.
                if (cnt_last) begin
                    if (!run_req || (flag_dir != dir_q)) begin
                        state_d = StIdle;
                    end else begin
                        half_d  = half_ramp;
                        cnt_d   = half_ramp;
                        state_d = StHigh;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            half_q  <= 16'(HALF_START);
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            dir_q   <= dir_d;
            step_q  <= (state_d == StHigh);
            en_q    <= (state_d != StIdle);
        end
    end

    assign motor_step = step_q;
    assign motor_dir  = dir_q;
    assign motor_en   = en_q;
    assign busy       = (state_q != StIdle);

`ifdef STEP_POS_EN
    logic [CNT_W-1:0] pos_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || pos_clr) begin
            pos_q <= '0;
        end else if ((state_d == StHigh) && (state_q != StHigh)) begin
            pos_q <= dir_q ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
        end
    end

    assign step_pos = pos_q;
`endif

endmodule

// File: tb/tb_motor_step_gen.sv
// Directed bench for motor_step_gen: per-cycle vector table plus multi-cycle corner sequences.
// Position-counter checks are built only when STEP_POS_EN is defined.
module tb_motor_step_gen;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] motor_flag;
    logic       motor_step, motor_dir, motor_en, busy;
`ifdef STEP_POS_EN
    logic       pos_clr;
    logic [3:0] step_pos;
`endif

    int n_chk = 0;
    int n_err = 0;

    motor_step_gen #(
        .HALF_START(8),
        .HALF_MIN  (4),
        .RAMP_STEP (2),
        .DIR_SETUP (3),
        .CNT_W     (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .motor_flag(motor_flag),
`ifdef STEP_POS_EN
        .pos_clr   (pos_clr),
        .step_pos  (step_pos),
`endif
        .motor_step(motor_step),
        .motor_dir (motor_dir),
        .motor_en  (motor_en),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       rst;
        logic [1:0] flag;
        int         n;
        logic       step;
        logic       en;
        logic       dir;
        logic       chk_dir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] flag, input int n, input logic step,
                       input logic en, input logic dir, input logic chk_dir);
        vec_t v;
        v.rst = rst; v.flag = flag; v.n = n; v.step = step; v.en = en; v.dir = dir;
        v.chk_dir = chk_dir;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hi, rises;
        logic prev, done;
        logic [3:0] got, exp;

        sys_rst    = 1'b1;
        motor_flag = 2'd0;
`ifdef STEP_POS_EN
        pos_clr    = 1'b0;
`endif
        //   rst  flag  n  step en dir chk_dir
        add(1'b1, 2'd0,  3, 1'b0, 1'b0, 1'b0, 1'b1);  // reset state
        add(1'b0, 2'd3, 20, 1'b0, 1'b0, 1'b0, 1'b1);  // flag 3 = stop
        add(1'b0, 2'd1,  3, 1'b0, 1'b1, 1'b0, 1'b1);  // setup
        add(1'b0, 2'd1,  8, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  8, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  6, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  6, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  4, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  4, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  4, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  4, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  1, 1'b1, 1'b1, 1'b0, 1'b1);  // high cycle 1 at half=4
        add(1'b0, 2'd0,  3, 1'b1, 1'b1, 1'b0, 1'b1);  // stop mid-pulse, pulse completes
        add(1'b0, 2'd0,  4, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd0,  3, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 2'd1,  3, 1'b0, 1'b1, 1'b0, 1'b1);  // reversal run
        add(1'b0, 2'd1,  8, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd2,  8, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd2,  1, 1'b0, 1'b0, 1'b0, 1'b0);  // single idle cycle
        add(1'b0, 2'd2,  3, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 2'd2,  8, 1'b1, 1'b1, 1'b1, 1'b1);  // restarts at HALF_START
        add(1'b0, 2'd2,  8, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 2'd2,  6, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 2'd0,  6, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 2'd0,  2, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd1,  3, 1'b0, 1'b1, 1'b0, 1'b1);  // reset mid-pulse
        add(1'b0, 2'd1,  3, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b1, 2'd1,  2, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 2'd1,  3, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd1,  8, 1'b1, 1'b1, 1'b0, 1'b1);  // half back at 8
        add(1'b0, 2'd0,  8, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 2'd0,  2, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                sys_rst    = vecs[i].rst;
                motor_flag = vecs[i].flag;
                tick();
                got = {motor_step, motor_en, busy, motor_dir};
                exp = {vecs[i].step, vecs[i].en, vecs[i].en, vecs[i].dir};
                if (!vecs[i].chk_dir) begin
                    got[0] = 1'b0;
                    exp[0] = 1'b0;
                end
                check($sformatf("row%0d_cyc%0d step/en/busy/dir", i, k), int'(got), int'(exp));
            end
        end

        // Stop seen during SETUP: back to idle with no pulse.
        sys_rst    = 1'b0;
        motor_flag = 2'd1;
        tick();
        check("setup_entry_en", int'(motor_en), 1);
        motor_flag = 2'd0;
        tick();
        check("setup_abort_busy", int'(busy), 0);
        check("setup_abort_en", int'(motor_en), 0);
        hi = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (motor_step) hi++;
        end
        check("setup_abort_no_step", hi, 0);

        // First-rise latency and first pulse width.
        motor_flag = 2'd1;
        lat  = 0;
        done = 1'b0;
        for (int c = 1; c <= 50 && !done; c++) begin
            tick();
            if (motor_step) begin
                lat  = c;
                done = 1'b1;
            end
        end
        check("first_rise_latency", lat, 4);
        hi = 1;
        for (int c = 0; c < 50 && motor_step; c++) begin
            tick();
            if (motor_step) hi++;
        end
        check("first_high_width", hi, 8);
        motor_flag = 2'd0;
        for (int c = 0; c < 100 && busy; c++) tick();
        check("stop_reaches_idle", int'(busy), 0);

`ifdef STEP_POS_EN
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        check("pos_clear", int'(step_pos), 0);

        // 17 right steps wrap a 4-bit counter to 1.
        motor_flag = 2'd2;
        rises = 0;
        prev  = motor_step;
        for (int c = 0; c < 2000 && rises < 17; c++) begin
            tick();
            if (motor_step && !prev) rises++;
            prev = motor_step;
        end
        check("pos_rises", rises, 17);
        check("pos_wrap", int'(step_pos), 1);

        // pos_clr held across a HIGH entry wins over the count.
        pos_clr = 1'b1;
        for (int c = 0; c < 100 && motor_step; c++) tick();
        for (int c = 0; c < 100 && !motor_step; c++) tick();
        pos_clr = 1'b0;
        check("pos_clr_on_entry_step", int'(motor_step), 1);
        check("pos_clr_priority", int'(step_pos), 0);
        for (int c = 0; c < 100 && motor_step; c++) tick();
        for (int c = 0; c < 100 && !motor_step; c++) tick();
        check("pos_after_clr", int'(step_pos), 1);
        motor_flag = 2'd0;
        for (int c = 0; c < 100 && busy; c++) tick();
        check("pos_stop_idle", int'(busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/motor_step_gen.md
MOTOR_STEP_GEN -- requirements
Module: motor_step_gen

Interface
REQ-001 Parameter HALF_START, 2500, initial step half-period in sys_clk cycles; SHALL be >= HALF_MIN.
REQ-002 Parameter HALF_MIN, 250, minimum (cruise) step half-period in cycles; SHALL be >= 1.
REQ-003 Parameter RAMP_STEP, 10, half-period decrement applied per completed step.
REQ-004 Parameter DIR_SETUP, 50, cycles motor_en/motor_dir are held stable before the first step pulse; SHALL be >= 1.
REQ-005 Parameter CNT_W, 16, width of step_pos.
REQ-006 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-007 sys_rst  in  1  reset; synchronous and active-high.
REQ-008 motor_flag  in  2  command from the position-reset FSM: 0 = stop, 1 = run dir 0 (left), 2 = run dir 1 (right), 3 = treated as stop.
REQ-009 pos_clr  in  1  synchronous clear of step_pos; present only with STEP_POS_EN.
REQ-010 motor_step  out  1  registered step pulse to the driver.
REQ-011 motor_dir  out  1  registered direction: 0 = left, 1 = right.
REQ-012 motor_en  out  1  registered driver enable, high in every state except IDLE.
REQ-013 busy  out  1  high when state != IDLE.
REQ-014 step_pos  out  CNT_W  signed step position; present only with STEP_POS_EN.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETUP, HIGH and LOW, with one 16-bit cycle counter and a 16-bit register half.
REQ-016 In IDLE, motor_flag of 1 or 2 SHALL latch dir (flag 1 -> 0, flag 2 -> 1), load half = HALF_START and the counter = DIR_SETUP, and enter SETUP; motor_en and motor_dir SHALL be valid on the next cycle.
REQ-017 SETUP SHALL last DIR_SETUP cycles and then enter HIGH; a stop flag (0 or 3) seen in SETUP SHALL return the FSM to IDLE without any step pulse.
REQ-018 In HIGH, motor_step SHALL be 1 for exactly half cycles, after which the FSM enters LOW.
REQ-019 In LOW, motor_step SHALL be 0 for exactly half cycles.
REQ-020 At the end of LOW, the FSM SHALL enter IDLE if the flag is a stop or commands the opposite direction; otherwise half SHALL become max(half - RAMP_STEP, HALF_MIN), with no underflow, and the FSM SHALL enter HIGH.
REQ-021 A step pulse SHALL never be truncated: a stop or reversal arriving in HIGH or LOW takes effect only at the end of LOW.
REQ-022 A reversal SHALL pass through IDLE for one cycle and then through a full SETUP, and SHALL restart at HALF_START.
REQ-023 The first rising edge of motor_step SHALL occur DIR_SETUP+1 cycles after the cycle in which a run flag is sampled in IDLE.
REQ-024 With STEP_POS_EN, each entry into HIGH SHALL add 1 to step_pos when dir = 1 and subtract 1 when dir = 0, wrapping modulo 2^CNT_W.
REQ-025 pos_clr SHALL have priority: when pos_clr coincides with a HIGH entry, step_pos SHALL be 0 and that step is not counted.

Reset
REQ-026 While sys_rst = 1, the block SHALL force state = IDLE, motor_step = 0, motor_dir = 0, motor_en = 0, busy = 0, half = HALF_START, counter = 0 and step_pos = 0 from the next clock edge.
REQ-027 Reset asserted mid-pulse SHALL abort the pulse immediately; this is the only case in which truncation is allowed.

Configuration
REQ-028 With macro STEP_POS_EN defined, the pos_clr port, the step_pos port and the position counter SHALL be compiled in.
REQ-029 Without STEP_POS_EN, those ports and that logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (HALF_START=8, HALF_MIN=4, RAMP_STEP=2, DIR_SETUP=3, CNT_W=4)
REQ-030 Release reset, then motor_flag=1 sampled at cycle 0 -> en=1 and dir=0 at cycle 1, step rises at cycle 4, high/low lengths are 8,8 then 6,6 then 4,4 and stay 4 thereafter.
REQ-031 Running at half=4, motor_flag=0 on the 2nd cycle of HIGH -> pulse completes 4 high + 4 low cycles, then en=0 and busy=0.
REQ-032 Running with flag=1, flag switches to 2 -> current pulse completes, one IDLE cycle, dir=1, 3 SETUP cycles, next pulse high for 8 cycles.
REQ-033 motor_flag=3 held in IDLE for 20 cycles -> en=0 and step=0 throughout.
REQ-034 17 steps with dir=1 -> step_pos=1 (wrap); then pos_clr asserted on a HIGH entry -> step_pos=0.
REQ-035 sys_rst=1 on the 3rd cycle of HIGH -> step=0, en=0 and busy=0 at the next edge; after release the FSM restarts from IDLE with half=8.
